write_buffer: RTL and testbench
===============================

// Module: write_buffer
// PURPOSE
//  Byte-to-word packer and memory write sequencer: the producer end of the byte/word memory path.
//  Packs the incoming byte stream into 16-bit words, low byte first, and queues them in a small word FIFO.
//  Writes each word to external memory with a timed WRITE_CMD pulse.
//  Publishes WRITE_ADDRESS, the count of committed words, which the downstream reader polls for data availability.
// PARAMETERS
//  FIFO_DEPTH  4         words of queue between the packer and the memory FSM (power of 2, >=2)
//  WR_PULSE    4         CLK_48MHZ cycles WRITE_CMD is held high per word
//  WR_GAP      2         cycles WRITE_CMD is held low after each pulse before the next setup
//  ADDR_MAX    18'h3FFFF last valid word address
//  PAD_BYTE    8'h00     upper byte used when FLUSH completes an odd byte
// PORTS
//  CLK_48MHZ     in   1   system clock
//  RESET         in   1   asynchronous, active-low reset
//  BYTE_IN       in   8   data byte; valid only with BYTE_STROBE
//  BYTE_STROBE   in   1   1-cycle synchronous strobe; accept BYTE_IN
//  FLUSH         in   1   1-cycle strobe; complete a half-packed word using PAD_BYTE
//  MEM_BUSY      in   1   memory owned by the reader; sampled only in IDLE
//  WRITE_CMD     out  1   memory write strobe, active high
//  DATA_WRITE    out  16  word to memory; stable from SETUP through the end of STROBE
//  WRITE_ADDRESS out  18  address of next word = number of words committed
//  FIFO_FULL     out  1   word FIFO holds FIFO_DEPTH entries
//  OVERFLOW      out  1   sticky; a word was dropped (FIFO full or memory end)
//  MEM_FULL      out  1   WRITE_ADDRESS passed ADDR_MAX (non-wrap build only)
// BEHAVIOUR
//  Reset values: all outputs 0; FSM IDLE; packer empty; FIFO empty.
//  Reset mid-write: WRITE_CMD drops asynchronously; the partial word is lost.
//  Packer:
//   - Strobe #1 latches the low byte and sets half-full.
//   - Strobe #2 pushes {BYTE_IN, low} into the FIFO at the next edge (1-cycle latency).
//   - FLUSH while half-full pushes {PAD_BYTE, low}; FLUSH while empty is a no-op.
//   - BYTE_STROBE and FLUSH in the same cycle: the byte is taken first, then FLUSH acts on the result.
//     A completed word plus FLUSH pushes exactly one word; a first byte plus FLUSH pushes a padded word.
//  FIFO:
//   - Push and pop in the same cycle are both honoured; the count is unchanged.
//   - A push while full and not popping drops the word and sets OVERFLOW.
//  Write FSM: IDLE -> SETUP -> STROBE -> RECOVER -> IDLE.
//   - IDLE: go to SETUP when the FIFO is non-empty and MEM_BUSY=0 (and MEM_FULL=0).
//   - SETUP (1 cycle): DATA_WRITE <= FIFO head; WRITE_CMD=0.
//   - STROBE (WR_PULSE cycles): WRITE_CMD=1; MEM_BUSY is ignored here.
//   - RECOVER (WR_GAP cycles): WRITE_CMD=0. On the first RECOVER cycle, pop the FIFO and increment WRITE_ADDRESS.
//  Throughput: 1 word per 1+WR_PULSE+WR_GAP+1 cycles (8 at defaults); a strobe pair is expected every >=8 cycles.
//  WRITE_ADDRESS is 18-bit unsigned and changes only in RECOVER, so the reader never sees an address for an unwritten word.
// CONFIGURATION
//  Macro ADDR_WRAP_EN:
//   - Defined: after ADDR_MAX, WRITE_ADDRESS wraps to 0 (ring log); MEM_FULL stays 0.
//   - Undefined: after writing ADDR_MAX, WRITE_ADDRESS saturates at ADDR_MAX+1 (truncated to 0 at 18 bits, so a
//     separate full flag is held) and MEM_FULL=1. The FSM stays in IDLE; queued and new words drop with OVERFLOW=1.
// STRUCTURE
//  Shared package wbuf_pkg: FSM state encoding (IDLE, SETUP, STROBE, RECOVER), ADDR_W=18, WORD_W=16, BYTE_W=8.
//  Sub-module write_word_fifo: synchronous FIFO (FIFO_DEPTH x 16) with push, pop, full, empty; async active-low reset.
//  Packer and write FSM stay in write_buffer.
// TESTING
//  T1: strobe 8'hA5 then 8'h3C, MEM_BUSY=0 -> one WRITE_CMD pulse of 4 cycles with DATA_WRITE=16'h3CA5;
//      WRITE_ADDRESS 0->1.
//  T2: strobe 8'h11, then FLUSH -> DATA_WRITE=16'h0011 written; a second FLUSH writes nothing.
//  T3: hold MEM_BUSY=1 and strobe 10 bytes -> FIFO_FULL after 8 bytes, OVERFLOW=1 at byte 10; release MEM_BUSY ->
//      exactly 4 writes, WRITE_ADDRESS=4.
//  T4: MEM_BUSY raised mid-STROBE -> pulse completes at full width; the next SETUP waits for MEM_BUSY=0.
//  T5: preload WRITE_ADDRESS=ADDR_MAX, write 2 words -> ADDR_WRAP_EN: address 0 then 1;
//      without the macro: one write, MEM_FULL=1, OVERFLOW=1.
//  T6: assert RESET during STROBE -> WRITE_CMD=0 immediately; all outputs 0; the next byte pair writes to address 0.

Source files
------------

// File: rtl/wbuf_pkg.sv
// ----------------------------------------------------------------------------
// wbuf_pkg
// Shared definitions for the byte-to-word write path: bus widths, the write
// sequencer state encoding and the byte packing helper.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
package wbuf_pkg;
   localparam int ADDR_W = 18;
   localparam int WORD_W = 16;
   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETUP   = 2'd1,
      ST_STROBE  = 2'd2,
      ST_RECOVER = 2'd3
   } wr_state_t;

   // Words are stored low byte first: the first byte received lands in [7:0].
   function automatic logic [WORD_W-1:0] pack_word(input logic [BYTE_W-1:0] hi,
                                                   input logic [BYTE_W-1:0] lo);
      return {hi, lo};
   endfunction
endpackage

// File: rtl/write_word_fifo.sv
// ----------------------------------------------------------------------------
// write_word_fifo
// Synchronous word FIFO between the byte packer and the memory write FSM.
// Ports:
//   CLK_48MHZ  in   clock
//   RESET      in   asynchronous active-low reset
//   i_push     in   write i_data (ignored when full unless popping this cycle)
//   i_pop      in   drop the head entry (ignored when empty)
//   i_data     in   word to queue
//   o_head     out  oldest queued word
//   o_full     out  DEPTH entries held
//   o_empty    out  no entries held
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module write_word_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic             CLK_48MHZ,
   input  logic             RESET,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_full    = (r_count == CNT_FULL);
   assign o_empty   = (r_count == {CNT_W{1'b0}});
   assign o_head    = r_mem[r_rd_ptr];
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push_ok = i_push & (~o_full | i_pop);
   assign w_pop_ok  = i_pop & ~o_empty;

   // Storage array; no reset needed, entries are only read once written.
   always_ff @(posedge CLK_48MHZ) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers and occupancy count.
   always_ff @(posedge CLK_48MHZ or negedge RESET) begin
      if (!RESET) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {CNT_W{1'b0}};
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/write_buffer.sv
// ----------------------------------------------------------------------------
// write_buffer
// Packs a byte stream into 16-bit words (low byte first), queues them and
// writes each word to external memory with a timed WRITE_CMD pulse.
// WRITE_ADDRESS counts committed words; the reader polls it.
// Build option: define ADDR_WRAP_EN to wrap WRITE_ADDRESS to 0 after
// ADDR_MAX (ring log). Without it the address saturates and MEM_FULL is set.
// Ports:
//   CLK_48MHZ      in   system clock
//   RESET          in   asynchronous active-low reset
//   BYTE_IN[7:0]   in   data byte, valid with BYTE_STROBE
//   BYTE_STROBE    in   accept BYTE_IN this cycle
//   FLUSH          in   complete a half-packed word with PAD_BYTE
//   MEM_BUSY       in   memory owned by the reader (checked only in IDLE)
//   WRITE_CMD      out  memory write strobe
//   DATA_WRITE     out  word being written
//   WRITE_ADDRESS  out  address of the next word
//   FIFO_FULL      out  word queue full
//   OVERFLOW       out  sticky, a word was dropped
//   MEM_FULL       out  address space exhausted (non-wrap build)
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module write_buffer
   import wbuf_pkg::*;
#(
   parameter int                FIFO_DEPTH = 4,
   parameter int                WR_PULSE   = 4,
   parameter int                WR_GAP     = 2,
   parameter logic [ADDR_W-1:0] ADDR_MAX   = 18'h3FFFF,
   parameter logic [BYTE_W-1:0] PAD_BYTE   = 8'h00
) (
   input  logic              CLK_48MHZ,
   input  logic              RESET,
   input  logic [BYTE_W-1:0] BYTE_IN,
   input  logic              BYTE_STROBE,
   input  logic              FLUSH,
   input  logic              MEM_BUSY,
   output logic              WRITE_CMD,
   output logic [WORD_W-1:0] DATA_WRITE,
   output logic [ADDR_W-1:0] WRITE_ADDRESS,
   output logic              FIFO_FULL,
   output logic              OVERFLOW,
   output logic              MEM_FULL
);
   localparam logic [7:0] PULSE_LAST = 8'(WR_PULSE - 1);
   localparam logic [7:0] GAP_LAST   = 8'(WR_GAP - 1);

   wr_state_t         r_state, w_state_next;
   logic [7:0]        r_cnt, w_cnt_next;
   logic              r_half, w_half_next;
   logic [BYTE_W-1:0] r_low, w_low_next;
   logic              w_push;
   logic [WORD_W-1:0] w_push_data;
   logic [WORD_W-1:0] w_head;
   logic              w_full, w_empty;
   logic              w_pop, w_pop_write, w_pop_drain, w_drop;
   logic              r_write_cmd, r_overflow, r_mem_full;
   logic [WORD_W-1:0] r_data_write;
   logic [ADDR_W-1:0] r_addr;

   assign WRITE_CMD     = r_write_cmd;
   assign DATA_WRITE    = r_data_write;
   assign WRITE_ADDRESS = r_addr;
   assign FIFO_FULL     = w_full;
   assign OVERFLOW      = r_overflow;
   assign MEM_FULL      = r_mem_full;

   // Packer: the strobed byte is absorbed first, then FLUSH acts on the result.
   always_comb begin
      w_push      = 1'b0;
      w_push_data = {WORD_W{1'b0}};
      w_half_next = r_half;
      w_low_next  = r_low;
      if (BYTE_STROBE) begin
         if (r_half) begin
            w_push      = 1'b1;
            w_push_data = pack_word(BYTE_IN, r_low);
            w_half_next = 1'b0;
         end else if (FLUSH) begin
            w_push      = 1'b1;
            w_push_data = pack_word(PAD_BYTE, BYTE_IN);
            w_half_next = 1'b0;
         end else begin
            w_low_next  = BYTE_IN;
            w_half_next = 1'b1;
         end
      end else if (FLUSH && r_half) begin
         w_push      = 1'b1;
         w_push_data = pack_word(PAD_BYTE, r_low);
         w_half_next = 1'b0;
      end else begin
         w_half_next = r_half;
      end
   end

   // Head leaves on the first RECOVER cycle; once memory is full the queue drains as drops.
   assign w_pop_write = (r_state == ST_RECOVER) && (r_cnt == GAP_LAST);
   assign w_pop_drain = r_mem_full & ~w_empty;
   assign w_pop       = w_pop_write | w_pop_drain;
   assign w_drop      = w_push & (r_mem_full | (w_full & ~w_pop));

   write_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WORD_W)
   ) u_fifo (
      .CLK_48MHZ (CLK_48MHZ),
      .RESET     (RESET),
      .i_push    (w_push & ~r_mem_full),
      .i_pop     (w_pop),
      .i_data    (w_push_data),
      .o_head    (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   // Write FSM next state and phase counter.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty && !MEM_BUSY && !r_mem_full) begin
               w_state_next = ST_SETUP;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_SETUP: begin
            w_state_next = ST_STROBE;
            w_cnt_next   = PULSE_LAST;
         end
         ST_STROBE: begin
            if (r_cnt == 8'd0) begin
               w_state_next = ST_RECOVER;
               w_cnt_next   = GAP_LAST;
            end else begin
               w_cnt_next   = r_cnt - 8'd1;
            end
         end
         ST_RECOVER: begin
            if (r_cnt == 8'd0) begin
               w_state_next = ST_IDLE;
            end else begin
               w_cnt_next   = r_cnt - 8'd1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_cnt_next   = 8'd0;
         end
      endcase
   end

   // Sequential state: FSM, packer, registered outputs and address counter.
   always_ff @(posedge CLK_48MHZ or negedge RESET) begin
      if (!RESET) begin
         r_state      <= ST_IDLE;
         r_cnt        <= 8'd0;
         r_half       <= 1'b0;
         r_low        <= {BYTE_W{1'b0}};
         r_write_cmd  <= 1'b0;
         r_data_write <= {WORD_W{1'b0}};
         r_addr       <= {ADDR_W{1'b0}};
         r_overflow   <= 1'b0;
         r_mem_full   <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_half      <= w_half_next;
         r_low       <= w_low_next;
         // Registered from next state so the pulse spans exactly the STROBE cycles.
         r_write_cmd <= (w_state_next == ST_STROBE);
         if ((r_state == ST_IDLE) && (w_state_next == ST_SETUP)) begin
            r_data_write <= w_head;
         end
         if (w_drop || w_pop_drain) begin
            r_overflow <= 1'b1;
         end
         if (w_pop_write) begin
`ifdef ADDR_WRAP_EN
            if (r_addr == ADDR_MAX) begin
               r_addr <= {ADDR_W{1'b0}};
            end else begin
               r_addr <= r_addr + 18'd1;
            end
`else
            // At the top of memory this yields ADDR_MAX+1 (0 at full range), hence the flag.
            r_addr <= r_addr + 18'd1;
            if (r_addr == ADDR_MAX) begin
               r_mem_full <= 1'b1;
            end
`endif
         end
      end
   end
endmodule

// File: tb/tb_write_buffer.sv
`timescale 1ns/1ps
module tb_write_buffer;
   localparam logic [17:0] TB_ADDR_MAX = 18'd7;
   localparam int          TB_PULSE    = 4;

   logic        CLK_48MHZ = 1'b0;
   logic        RESET = 1'b0;
   logic [7:0]  BYTE_IN = 8'h00;
   logic        BYTE_STROBE = 1'b0;
   logic        FLUSH = 1'b0;
   logic        MEM_BUSY = 1'b0;
   logic        WRITE_CMD;
   logic [15:0] DATA_WRITE;
   logic [17:0] WRITE_ADDRESS;
   logic        FIFO_FULL;
   logic        OVERFLOW;
   logic        MEM_FULL;

   always #10 CLK_48MHZ = ~CLK_48MHZ;

   write_buffer #(.ADDR_MAX(TB_ADDR_MAX)) dut (
      .CLK_48MHZ     (CLK_48MHZ),
      .RESET         (RESET),
      .BYTE_IN       (BYTE_IN),
      .BYTE_STROBE   (BYTE_STROBE),
      .FLUSH         (FLUSH),
      .MEM_BUSY      (MEM_BUSY),
      .WRITE_CMD     (WRITE_CMD),
      .DATA_WRITE    (DATA_WRITE),
      .WRITE_ADDRESS (WRITE_ADDRESS),
      .FIFO_FULL     (FIFO_FULL),
      .OVERFLOW      (OVERFLOW),
      .MEM_FULL      (MEM_FULL)
   );

   typedef struct {
      logic [15:0] data;
      logic [17:0] addr;
      int          width;
      logic        stable;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         obs_q[$];
   int          checks = 0;
   int          passed = 0;
   logic [17:0] exp_addr = 18'd0;

   int          mon_width = 0;
   logic [15:0] mon_data;
   logic [17:0] mon_addr;
   logic        mon_stable;

   // Records every completed WRITE_CMD pulse; a reset discards a partial pulse.
   always @(negedge CLK_48MHZ or negedge RESET) begin
      if (!RESET) begin
         mon_width = 0;
      end else if (WRITE_CMD === 1'b1) begin
         if (mon_width == 0) begin
            mon_data   = DATA_WRITE;
            mon_addr   = WRITE_ADDRESS;
            mon_stable = 1'b1;
         end else if (DATA_WRITE !== mon_data || WRITE_ADDRESS !== mon_addr) begin
            mon_stable = 1'b0;
         end
         mon_width = mon_width + 1;
      end else if (mon_width > 0) begin
         obs_q.push_back('{mon_data, mon_addr, mon_width, mon_stable});
         mon_width = 0;
      end
   end

   task automatic tick();
      @(posedge CLK_48MHZ);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic f);
      BYTE_IN     = b;
      BYTE_STROBE = 1'b1;
      FLUSH       = f;
      tick();
      BYTE_STROBE = 1'b0;
      FLUSH       = 1'b0;
   endtask

   task automatic do_flush();
      FLUSH = 1'b1;
      tick();
      FLUSH = 1'b0;
   endtask

   // Scoreboard entry for a word the bench expects to reach memory.
   task automatic expect_word(input logic [15:0] d);
      exp_q.push_back('{d, exp_addr, TB_PULSE, 1'b1});
`ifdef ADDR_WRAP_EN
      exp_addr = (exp_addr == TB_ADDR_MAX) ? 18'd0 : exp_addr + 18'd1;
`else
      exp_addr = exp_addr + 18'd1;
`endif
   endtask

   // Waits (bounded) for n recorded writes, then idles to expose any extra write.
   task automatic wait_writes(input int n, input int budget);
      for (int i = 0; i < budget && obs_q.size() < n; i++) tick();
      repeat (16) tick();
   endtask

   task automatic do_reset();
      BYTE_STROBE = 1'b0;
      FLUSH       = 1'b0;
      MEM_BUSY    = 1'b0;
      RESET       = 1'b0;
      repeat (2) tick();
      RESET = 1'b1;
      tick();
      exp_q.delete();
      obs_q.delete();
      exp_addr = 18'd0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({WRITE_CMD, DATA_WRITE, WRITE_ADDRESS, FIFO_FULL, OVERFLOW, MEM_FULL} !== 38'd0)
         $display("FAIL reset_outputs: got cmd=%b data=%h addr=%h ff=%b ov=%b mf=%b, want all 0",
                  WRITE_CMD, DATA_WRITE, WRITE_ADDRESS, FIFO_FULL, OVERFLOW, MEM_FULL);
      else passed++;
   endtask

   task automatic test_pair_write();
      send_byte(8'hA5, 1'b0);
      send_byte(8'h3C, 1'b0);
      expect_word(16'h3CA5);
      wait_writes(1, 100);
      checks++;
      if (obs_q.size() != 1) $display("FAIL t1_count: got %0d writes, want 1", obs_q.size());
      else passed++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         wr_t o = obs_q.pop_front();
         wr_t e = exp_q.pop_front();
         checks++;
         if (o.data !== e.data || o.addr !== e.addr || o.width != e.width || o.stable !== 1'b1)
            $display("FAIL t1_write: got data=%h addr=%h width=%0d stable=%b, want data=%h addr=%h width=%0d",
                     o.data, o.addr, o.width, o.stable, e.data, e.addr, e.width);
         else passed++;
      end
      checks++;
      if (WRITE_ADDRESS !== 18'd1) $display("FAIL t1_addr: got %h, want 1", WRITE_ADDRESS);
      else passed++;
   endtask

   task automatic test_flush();
      send_byte(8'h11, 1'b0);
      do_flush();
      expect_word(16'h0011);
      repeat (4) tick();
      do_flush();                     // empty packer: nothing to push
      send_byte(8'h22, 1'b1);         // first byte + FLUSH: padded word
      expect_word(16'h0022);
      repeat (8) tick();
      send_byte(8'h33, 1'b0);
      send_byte(8'h44, 1'b1);         // completed word + FLUSH: exactly one word
      expect_word(16'h4433);
      wait_writes(3, 200);
      checks++;
      if (obs_q.size() != 3) $display("FAIL t2_count: got %0d writes, want 3", obs_q.size());
      else passed++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         wr_t o = obs_q.pop_front();
         wr_t e = exp_q.pop_front();
         checks++;
         if (o.data !== e.data || o.addr !== e.addr || o.width != e.width || o.stable !== 1'b1)
            $display("FAIL t2_write: got data=%h addr=%h width=%0d stable=%b, want data=%h addr=%h width=%0d",
                     o.data, o.addr, o.width, o.stable, e.data, e.addr, e.width);
         else passed++;
      end
      checks++;
      if (WRITE_ADDRESS !== 18'd4) $display("FAIL t2_addr: got %h, want 4", WRITE_ADDRESS);
      else passed++;
   endtask

   task automatic test_fifo_overflow();
      do_reset();
      MEM_BUSY = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         send_byte(8'h50 + 8'(i), 1'b0);
         if (i % 2 == 1 && i < 8) expect_word({8'h50 + 8'(i), 8'h50 + 8'(i - 1)});
         if (i == 6) begin
            checks++;
            if (FIFO_FULL !== 1'b0 || OVERFLOW !== 1'b0)
               $display("FAIL t3_before_full: got ff=%b ov=%b, want 0 0", FIFO_FULL, OVERFLOW);
            else passed++;
         end
         if (i == 7) begin
            checks++;
            if (FIFO_FULL !== 1'b1 || OVERFLOW !== 1'b0)
               $display("FAIL t3_full: got ff=%b ov=%b, want 1 0", FIFO_FULL, OVERFLOW);
            else passed++;
         end
      end
      checks++;
      if (OVERFLOW !== 1'b1) $display("FAIL t3_overflow: got %b, want 1", OVERFLOW);
      else passed++;
      MEM_BUSY = 1'b0;
      wait_writes(4, 200);
      checks++;
      if (obs_q.size() != 4) $display("FAIL t3_count: got %0d writes, want 4", obs_q.size());
      else passed++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         wr_t o = obs_q.pop_front();
         wr_t e = exp_q.pop_front();
         checks++;
         if (o.data !== e.data || o.addr !== e.addr || o.width != e.width || o.stable !== 1'b1)
            $display("FAIL t3_write: got data=%h addr=%h width=%0d stable=%b, want data=%h addr=%h width=%0d",
                     o.data, o.addr, o.width, o.stable, e.data, e.addr, e.width);
         else passed++;
      end
      checks++;
      if (WRITE_ADDRESS !== 18'd4 || FIFO_FULL !== 1'b0)
         $display("FAIL t3_final: got addr=%h ff=%b, want 4 0", WRITE_ADDRESS, FIFO_FULL);
      else passed++;
   endtask

   task automatic test_busy_mid_strobe();
      do_reset();
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      expect_word(16'h0201);
      send_byte(8'h03, 1'b0);
      send_byte(8'h04, 1'b0);
      expect_word(16'h0403);
      for (int i = 0; i < 50 && WRITE_CMD !== 1'b1; i++) tick();
      checks++;
      if (WRITE_CMD !== 1'b1) $display("FAIL t4_start: got cmd=%b, want 1", WRITE_CMD);
      else passed++;
      tick();
      MEM_BUSY = 1'b1;
      wait_writes(1, 100);
      checks++;
      if (obs_q.size() != 1) $display("FAIL t4_held: got %0d writes while busy, want 1", obs_q.size());
      else passed++;
      MEM_BUSY = 1'b0;
      wait_writes(2, 100);
      checks++;
      if (obs_q.size() != 2) $display("FAIL t4_count: got %0d writes, want 2", obs_q.size());
      else passed++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         wr_t o = obs_q.pop_front();
         wr_t e = exp_q.pop_front();
         checks++;
         if (o.data !== e.data || o.addr !== e.addr || o.width != e.width || o.stable !== 1'b1)
            $display("FAIL t4_write: got data=%h addr=%h width=%0d stable=%b, want data=%h addr=%h width=%0d",
                     o.data, o.addr, o.width, o.stable, e.data, e.addr, e.width);
         else passed++;
      end
   endtask

   task automatic test_addr_end();
      int n_exp;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         send_byte(8'(8'h80 + 8'(i)), 1'b0);
         send_byte(8'(8'hC0 + 8'(i)), 1'b0);
         expect_word({8'(8'hC0 + 8'(i)), 8'(8'h80 + 8'(i))});
         repeat (8) tick();
      end
      send_byte(8'hE1, 1'b0);
      send_byte(8'hE2, 1'b0);
      expect_word(16'hE2E1);          // lands on ADDR_MAX in both builds
      send_byte(8'hF1, 1'b0);
      send_byte(8'hF2, 1'b0);
`ifdef ADDR_WRAP_EN
      expect_word(16'hF2F1);          // wraps to address 0
      n_exp = 9;
`else
      n_exp = 8;                      // dropped: memory full
`endif
      wait_writes(n_exp, 400);
      checks++;
      if (obs_q.size() != n_exp) $display("FAIL t5_count: got %0d writes, want %0d", obs_q.size(), n_exp);
      else passed++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         wr_t o = obs_q.pop_front();
         wr_t e = exp_q.pop_front();
         checks++;
         if (o.data !== e.data || o.addr !== e.addr || o.width != e.width || o.stable !== 1'b1)
            $display("FAIL t5_write: got data=%h addr=%h width=%0d stable=%b, want data=%h addr=%h width=%0d",
                     o.data, o.addr, o.width, o.stable, e.data, e.addr, e.width);
         else passed++;
      end
      checks++;
`ifdef ADDR_WRAP_EN
      if (WRITE_ADDRESS !== 18'd1 || MEM_FULL !== 1'b0 || OVERFLOW !== 1'b0)
         $display("FAIL t5_flags: got addr=%h mf=%b ov=%b, want 1 0 0", WRITE_ADDRESS, MEM_FULL, OVERFLOW);
      else passed++;
`else
      if (WRITE_ADDRESS !== TB_ADDR_MAX + 18'd1 || MEM_FULL !== 1'b1 || OVERFLOW !== 1'b1)
         $display("FAIL t5_flags: got addr=%h mf=%b ov=%b, want %h 1 1",
                  WRITE_ADDRESS, MEM_FULL, OVERFLOW, TB_ADDR_MAX + 18'd1);
      else passed++;
`endif
   endtask

   task automatic test_reset_mid_write();
      do_reset();
      send_byte(8'h5A, 1'b0);
      send_byte(8'h6B, 1'b0);
      for (int i = 0; i < 50 && WRITE_CMD !== 1'b1; i++) tick();
      checks++;
      if (WRITE_CMD !== 1'b1) $display("FAIL t6_start: got cmd=%b, want 1", WRITE_CMD);
      else passed++;
      tick();
      RESET = 1'b0;
      #1;
      checks++;
      if ({WRITE_CMD, DATA_WRITE, WRITE_ADDRESS, FIFO_FULL, OVERFLOW, MEM_FULL} !== 38'd0)
         $display("FAIL t6_async: got cmd=%b data=%h addr=%h ff=%b ov=%b mf=%b, want all 0",
                  WRITE_CMD, DATA_WRITE, WRITE_ADDRESS, FIFO_FULL, OVERFLOW, MEM_FULL);
      else passed++;
      repeat (2) tick();
      RESET = 1'b1;
      tick();
      obs_q.delete();
      exp_q.delete();
      exp_addr = 18'd0;
      send_byte(8'h77, 1'b0);
      send_byte(8'h88, 1'b0);
      expect_word(16'h8877);
      wait_writes(1, 100);
      checks++;
      if (obs_q.size() != 1) $display("FAIL t6_count: got %0d writes, want 1", obs_q.size());
      else passed++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         wr_t o = obs_q.pop_front();
         wr_t e = exp_q.pop_front();
         checks++;
         if (o.data !== e.data || o.addr !== e.addr || o.width != e.width || o.stable !== 1'b1)
            $display("FAIL t6_write: got data=%h addr=%h width=%0d stable=%b, want data=%h addr=%h width=%0d",
                     o.data, o.addr, o.width, o.stable, e.data, e.addr, e.width);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_pair_write();
      test_flush();
      test_fifo_overflow();
      test_busy_mid_strobe();
      test_addr_end();
      test_reset_mid_write();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
